acs_path_metric: RTL and testbench

//  Add-compare-select (ACS) and path-metric stage of the 4-state TCM Viterbi decoder.

---
 rtl/acs_path_metric.sv | 122 ++++++++++++
 tb/tb_acs_path_metric.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/acs_path_metric.sv
// Add-compare-select and path-metric stage of the 4-state TCM Viterbi decoder.
// Optional macro ACS_KNOWN_START_EN: frame start assumes the encoder begins in state 0.
module acs_path_metric #(
  parameter int BM_W = 3,
  parameter int PM_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            start,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  input  logic [BM_W-1:0] bm2,
  input  logic [BM_W-1:0] bm3,
  input  logic            bsel0,
  input  logic            bsel1,
  input  logic            bsel2,
  input  logic            bsel3,
  output logic            out_valid,
  output logic [3:0]      dec,
  output logic [3:0]      sel,
  output logic [1:0]      best_state,
  output logic [PM_W-1:0] pm0,
  output logic [PM_W-1:0] pm1,
  output logic [PM_W-1:0] pm2,
  output logic [PM_W-1:0] pm3
);

  localparam int              CW     = PM_W + 1;
  localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

  logic [PM_W-1:0] pm_q    [4];
  logic [PM_W-1:0] init_pm [4];
  logic [PM_W-1:0] old_pm  [4];
  logic [PM_W-1:0] surv    [4];
  logic [PM_W-1:0] pm_next [4];
  logic [CW-1:0]   cand_a  [4];
  logic [CW-1:0]   cand_b  [4];
  logic [CW-1:0]   win     [4];
  logic [BM_W-1:0] bm      [4];
  logic [3:0]      bsel;
  logic [3:0]      dec_next;
  logic [3:0]      sel_next;
  logic [PM_W-1:0] surv_min;
  logic [1:0]      best_next;

  assign bm[0] = bm0;
  assign bm[1] = bm1;
  assign bm[2] = bm2;
  assign bm[3] = bm3;
  assign bsel  = {bsel3, bsel2, bsel1, bsel0};

`ifdef ACS_KNOWN_START_EN
  assign init_pm[0] = '0;
  assign init_pm[1] = PM_MAX;
  assign init_pm[2] = PM_MAX;
  assign init_pm[3] = PM_MAX;
`else
  assign init_pm[0] = '0;
  assign init_pm[1] = '0;
  assign init_pm[2] = '0;
  assign init_pm[3] = '0;
`endif

  // State n is reached from {n[0],0} via subset n, or from {n[0],1} via subset n^2.
  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam int PA = (n % 2) * 2;
    localparam int PB = PA + 1;
    localparam int SB = n ^ 2;

    assign old_pm[n]   = start ? init_pm[n] : pm_q[n];
    assign cand_a[n]   = {1'b0, old_pm[PA]} + CW'(bm[n]);
    assign cand_b[n]   = {1'b0, old_pm[PB]} + CW'(bm[SB]);
    assign dec_next[n] = cand_a[n] > cand_b[n];
    assign sel_next[n] = dec_next[n] ? bsel[SB] : bsel[n];
    assign win[n]      = dec_next[n] ? cand_b[n] : cand_a[n];
    assign surv[n]     = (win[n] > {1'b0, PM_MAX}) ? PM_MAX : win[n][PM_W-1:0];
    assign pm_next[n]  = surv[n] - surv_min;
  end

  // Strict compares keep the lowest index on ties.
  always_comb begin
    surv_min  = surv[0];
    best_next = 2'd0;
    if (surv[1] < surv_min) begin
      surv_min  = surv[1];
      best_next = 2'd1;
    end
    if (surv[2] < surv_min) begin
      surv_min  = surv[2];
      best_next = 2'd2;
    end
    if (surv[3] < surv_min) begin
      surv_min  = surv[3];
      best_next = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pm_q       <= '{default: '0};
      dec        <= '0;
      sel        <= '0;
      best_state <= '0;
      out_valid  <= 1'b0;
    end else if (in_valid) begin
      pm_q       <= pm_next;
      dec        <= dec_next;
      sel        <= sel_next;
      best_state <= best_next;
      out_valid  <= 1'b1;
    end else begin
      out_valid  <= 1'b0;
    end
  end

  assign pm0 = pm_q[0];
  assign pm1 = pm_q[1];
  assign pm2 = pm_q[2];
  assign pm3 = pm_q[3];

endmodule

// File: tb/tb_acs_path_metric.sv
// Self-checking bench for acs_path_metric: directed steps plus randomized steps
// compared against a trellis-table reference model (honours ACS_KNOWN_START_EN).
module tb_acs_path_metric;

  localparam int PM_MAX = 63;
  localparam int FIRST_PRED  [4] = '{0, 2, 0, 2};
  localparam int FIRST_SUB   [4] = '{0, 1, 2, 3};
  localparam int SECOND_PRED [4] = '{1, 3, 1, 3};
  localparam int SECOND_SUB  [4] = '{2, 3, 0, 1};
`ifdef ACS_KNOWN_START_EN
  localparam bit KNOWN_START = 1'b1;
`else
  localparam bit KNOWN_START = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       start;
  logic [2:0] bm0, bm1, bm2, bm3;
  logic       bsel0, bsel1, bsel2, bsel3;
  logic       out_valid;
  logic [3:0] dec;
  logic [3:0] sel;
  logic [1:0] best_state;
  logic [5:0] pm0, pm1, pm2, pm3;

  int checks = 0;
  int errors = 0;

  int exp_pm [4];
  int exp_dec;
  int exp_sel;
  int exp_best;
  int exp_valid;

  acs_path_metric #(.BM_W(3), .PM_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .start      (start),
    .bm0        (bm0),
    .bm1        (bm1),
    .bm2        (bm2),
    .bm3        (bm3),
    .bsel0      (bsel0),
    .bsel1      (bsel1),
    .bsel2      (bsel2),
    .bsel3      (bsel3),
    .out_valid  (out_valid),
    .dec        (dec),
    .sel        (sel),
    .best_state (best_state),
    .pm0        (pm0),
    .pm1        (pm1),
    .pm2        (pm2),
    .pm3        (pm3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drives one cycle of inputs and advances the reference model over the same edge.
  task automatic applyStimulus(input bit rst_n, input bit v, input bit st,
                               input int b0, input int b1, input int b2, input int b3,
                               input bit [3:0] bs);
    int bmv [4];
    int old [4];
    int surv [4];
    int a, b, m, best, d, s;
    reset    = rst_n;
    in_valid = v;
    start    = st;
    bm0 = 3'(b0); bm1 = 3'(b1); bm2 = 3'(b2); bm3 = 3'(b3);
    {bsel3, bsel2, bsel1, bsel0} = bs;
    bmv = '{b0, b1, b2, b3};
    if (!rst_n) begin
      exp_pm    = '{0, 0, 0, 0};
      exp_dec   = 0;
      exp_sel   = 0;
      exp_best  = 0;
      exp_valid = 0;
    end else if (v) begin
      for (int n = 0; n < 4; n++)
        old[n] = st ? ((KNOWN_START && n != 0) ? PM_MAX : 0) : exp_pm[n];
      d = 0;
      s = 0;
      for (int n = 0; n < 4; n++) begin
        a = old[FIRST_PRED[n]] + bmv[FIRST_SUB[n]];
        b = old[SECOND_PRED[n]] + bmv[SECOND_SUB[n]];
        if (a <= b) begin
          surv[n] = a;
          s += int'(bs[FIRST_SUB[n]]) << n;
        end else begin
          surv[n] = b;
          d += 1 << n;
          s += int'(bs[SECOND_SUB[n]]) << n;
        end
        if (surv[n] > PM_MAX) surv[n] = PM_MAX;
      end
      m = surv[0];
      best = 0;
      for (int n = 1; n < 4; n++)
        if (surv[n] < m) begin
          m = surv[n];
          best = n;
        end
      for (int n = 0; n < 4; n++) exp_pm[n] = surv[n] - m;
      exp_dec   = d;
      exp_sel   = s;
      exp_best  = best;
      exp_valid = 1;
    end else begin
      exp_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".out_valid"},  32'(out_valid),  32'(exp_valid));
    chk({tag, ".dec"},        32'(dec),        32'(exp_dec));
    chk({tag, ".sel"},        32'(sel),        32'(exp_sel));
    chk({tag, ".best_state"}, 32'(best_state), 32'(exp_best));
    chk({tag, ".pm0"},        32'(pm0),        32'(exp_pm[0]));
    chk({tag, ".pm1"},        32'(pm1),        32'(exp_pm[1]));
    chk({tag, ".pm2"},        32'(pm2),        32'(exp_pm[2]));
    chk({tag, ".pm3"},        32'(pm3),        32'(exp_pm[3]));
  endtask

  initial begin
    $display("[TB] acs_path_metric bench, known start = %0d", KNOWN_START);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'h0);
    applyStimulus(0, 1, 1, 5, 5, 5, 5, 4'hF);
    checkOutput("reset");

    applyStimulus(1, 1, 1, 0, 7, 7, 7, 4'h0);
    checkOutput("start_first_step");

    applyStimulus(1, 1, 1, 3, 3, 3, 3, 4'hF);
    checkOutput("ties_0");
    applyStimulus(1, 1, 0, 3, 3, 3, 3, 4'hF);
    checkOutput("ties_1");
    applyStimulus(1, 1, 0, 3, 3, 3, 3, 4'hF);
    checkOutput("ties_2");

    applyStimulus(1, 1, 1, 0, 7, 0, 0, 4'h0);
    checkOutput("start_saturate");

    applyStimulus(1, 1, 0, 1, 4, 6, 2, 4'b0101);
    checkOutput("step_mixed");
    applyStimulus(1, 0, 1, 7, 7, 7, 7, 4'hF);
    checkOutput("idle_0");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'h0);
    checkOutput("idle_1");

    applyStimulus(1, 1, 0, 2, 5, 7, 1, 4'b1010);
    checkOutput("pre_reset_step");
    applyStimulus(0, 1, 0, 6, 1, 3, 4, 4'b0110);
    checkOutput("mid_frame_reset");

    for (int i = 0; i < 250; i++) begin
      applyStimulus($urandom_range(0, 39) != 0,
                    $urandom_range(0, 4) != 0,
                    $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)));
      checkOutput("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
